btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_pkg.sv | 26 ++
 rtl/btn_pulse_lane.sv | 149 ++++++++++++++
 rtl/btn_pulse_gen.sv | 49 ++++
 tb/tb_btn_pulse_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_pkg.sv
// -----------------------------------------------------------------------------
// btn_pulse_pkg
// Shared constants and types for the button pulse generator.
//   DEF_*          default cycle counts at 50 MHz (10 ms debounce,
//                  500 ms first repeat, 100 ms repeat period)
//   rep_state_t    auto-repeat state of one lane (IDLE, DELAY, REPEAT)
//   cnt_width()    counter width able to hold values 0..n
// -----------------------------------------------------------------------------
package btn_pulse_pkg;

   localparam int DEF_PORT_WIDTH    = 4;
   localparam int DEF_STABLE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY  = 25000000;
   localparam int DEF_REPEAT_PERIOD = 5000000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/btn_pulse_lane.sv
// -----------------------------------------------------------------------------
// btn_pulse_lane
// One button lane: 2-flop synchronizer, debounce counter, edge pulses and
// (optionally) auto-repeat strokes.
//   clk     system clock
//   reset   asynchronous, active-low reset
//   nbtn    raw pin, 0 = pressed, asynchronous to clk
//   level   debounced state, 1 = held
//   press   one-cycle pulse when level becomes 1
//   rel     one-cycle pulse when level becomes 0
//   stroke  one-cycle count-enable pulse (press, plus repeats if enabled)
// Build option: define BTN_PULSE_GEN_REPEAT_EN to add the auto-repeat FSM;
// without it REPEAT_DELAY / REPEAT_PERIOD have no effect.
// -----------------------------------------------------------------------------
module btn_pulse_lane
   import btn_pulse_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic nbtn,
   output logic level,
   output logic press,
   output logic rel,
   output logic stroke
);

   localparam int              CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync_reg;
   logic [CW-1:0] cnt_reg;
   logic          level_reg;
   logic          press_reg;
   logic          rel_reg;
   logic          stroke_reg;

   // A level change is accepted on the edge where the STABLE_CYCLES-th
   // consecutive disagreeing sample is seen.
   logic accept;
   logic rise;
   logic fall;

   assign accept = (sync_reg != level_reg) && (cnt_reg == CNT_LAST);
   assign rise   = accept & ~level_reg;
   assign fall   = accept &  level_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync_reg  <= 1'b0;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         press_reg <= 1'b0;
         rel_reg   <= 1'b0;
      end else begin
         // Inversion happens before the synchronizer so everything
         // downstream is positive logic.
         sync1_reg <= ~nbtn;
         sync_reg  <= sync1_reg;
         if (sync_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= ~level_reg;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         press_reg <= rise;
         rel_reg   <= fall;
      end
   end

`ifdef BTN_PULSE_GEN_REPEAT_EN
   localparam int TW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

   rep_state_t    state_reg;
   logic [TW-1:0] timer_reg;
   logic          expire;

   // Timer counts down to zero; the zero cycle is the expiry edge in both
   // DELAY and REPEAT.
   assign expire = (state_reg != IDLE) && (timer_reg == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         timer_reg  <= '0;
         stroke_reg <= 1'b0;
      end else begin
         // A release landing on an expiry edge swallows that repeat pulse.
         stroke_reg <= rise | (expire & ~fall);
         if (fall) begin
            state_reg <= IDLE;
            timer_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (rise) begin
                     state_reg <= DELAY;
                     timer_reg <= TW'(REPEAT_DELAY - 1);
                  end
               end
               DELAY: begin
                  if (timer_reg == '0) begin
                     state_reg <= REPEAT;
                     timer_reg <= TW'(REPEAT_PERIOD - 1);
                  end else begin
                     timer_reg <= timer_reg - 1'b1;
                  end
               end
               REPEAT: begin
                  if (timer_reg == '0) begin
                     timer_reg <= TW'(REPEAT_PERIOD - 1);
                  end else begin
                     timer_reg <= timer_reg - 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  timer_reg <= '0;
               end
            endcase
         end
      end
   end
`else
   // Repeat timing is irrelevant in this build.
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stroke_reg <= 1'b0;
      end else begin
         stroke_reg <= rise;
      end
   end
`endif

   assign level  = level_reg;
   assign press  = press_reg;
   assign rel    = rel_reg;
   assign stroke = stroke_reg;

endmodule

// File: rtl/btn_pulse_gen.sv
// -----------------------------------------------------------------------------
// btn_pulse_gen
// PORT_WIDTH independent button lanes: debounced level, press / release
// pulses and a stroke count-enable for a downstream address counter.
//   clk     system clock (50 MHz nominal)
//   reset   asynchronous, active-low reset
//   nbtn    raw pins, negative logic, asynchronous to clk
//   level   debounced state per lane, 1 = held
//   press   one-cycle pulse per lane on accepted 0->1 of level
//   rel     one-cycle pulse per lane on accepted 1->0 of level
//   stroke  one-cycle count-enable per lane
// Build option: BTN_PULSE_GEN_REPEAT_EN adds auto-repeat strokes while held.
// -----------------------------------------------------------------------------
module btn_pulse_gen
   import btn_pulse_pkg::*;
#(
   parameter int PORT_WIDTH    = DEF_PORT_WIDTH,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PORT_WIDTH-1:0] nbtn,
   output logic [PORT_WIDTH-1:0] level,
   output logic [PORT_WIDTH-1:0] press,
   output logic [PORT_WIDTH-1:0] rel,
   output logic [PORT_WIDTH-1:0] stroke
);

   generate
      for (genvar gi = 0; gi < PORT_WIDTH; gi++) begin : g_lane
         btn_pulse_lane #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
         ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .nbtn   (nbtn[gi]),
            .level  (level[gi]),
            .press  (press[gi]),
            .rel    (rel[gi]),
            .stroke (stroke[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_btn_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_btn_pulse_gen
// Directed scenarios followed by randomized pin activity, compared every
// cycle against a window-based reference model of the debouncer and a
// press-relative schedule for repeat strokes.
// -----------------------------------------------------------------------------
module tb_btn_pulse_gen;

   localparam int W  = 4;
   localparam int S  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] nbtn = '1;
   logic [W-1:0] level, press, rel, stroke;

   btn_pulse_gen #(
      .PORT_WIDTH    (W),
      .STABLE_CYCLES (S),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .nbtn   (nbtn),
      .level  (level),
      .press  (press),
      .rel    (rel),
      .stroke (stroke)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   // Level flips when the last S synchronized samples (since reset) all
   // disagree with it; sync is the pin sampled two edges earlier.
   logic [W-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_stroke;
   logic [S-1:0] m_win [W];
   int           m_seen [W];
   int           m_press_at [W];
   int           m_edge;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 <= '0; m_s2 <= '0; m_level <= '0;
         m_press <= '0; m_rel <= '0; m_stroke <= '0;
         m_edge <= 0;
         for (int i = 0; i < W; i++) begin
            m_win[i] <= '0;
            m_seen[i] <= 0;
            m_press_at[i] <= 0;
         end
      end else begin
         for (int ln = 0; ln < W; ln++) begin
            logic [S-1:0] w;
            logic r, f, s;
            w = {m_win[ln][S-2:0], m_s2[ln]};
            r = (m_seen[ln] + 1 >= S) && !m_level[ln] && (w == '1);
            f = (m_seen[ln] + 1 >= S) &&  m_level[ln] && (w == '0);
            s = r;
`ifdef BTN_PULSE_GEN_REPEAT_EN
            begin
               int d;
               d = m_edge - m_press_at[ln];
               if (m_level[ln] && !f && (d == RD || (d > RD && ((d - RD) % RP) == 0)))
                  s = 1'b1;
               if (r) m_press_at[ln] <= m_edge;
            end
`endif
            m_win[ln]    <= w;
            m_seen[ln]   <= (m_seen[ln] < S) ? m_seen[ln] + 1 : S;
            m_level[ln]  <= m_level[ln] ^ (r | f);
            m_press[ln]  <= r;
            m_rel[ln]    <= f;
            m_stroke[ln] <= s;
         end
         m_s1   <= ~nbtn;
         m_s2   <= m_s1;
         m_edge <= m_edge + 1;
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   int press_cnt [W];
   int rel_cnt [W];
   int stroke_cnt [W];
   int press_cyc [W];
   int rel_cyc [W];
   int stroke_cyc [W];

   initial begin
      for (int i = 0; i < W; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0; stroke_cnt[i] = 0;
         press_cyc[i] = -1; rel_cyc[i] = -1; stroke_cyc[i] = -1;
      end
   end

   always @(negedge clk) begin
      chk("level",  level,  m_level);
      chk("press",  press,  m_press);
      chk("rel",    rel,    m_rel);
      chk("stroke", stroke, m_stroke);
      if (reset) begin
         for (int ln = 0; ln < W; ln++) begin
            if (press[ln] === 1'b1)  begin press_cnt[ln]  <= press_cnt[ln] + 1;  press_cyc[ln]  <= cyc; end
            if (rel[ln] === 1'b1)    begin rel_cnt[ln]    <= rel_cnt[ln] + 1;    rel_cyc[ln]    <= cyc; end
            if (stroke[ln] === 1'b1) begin stroke_cnt[ln] <= stroke_cnt[ln] + 1; stroke_cyc[ln] <= cyc; end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0, tr, snap0, snap1;
      int prob;

      reset = 1'b0;
      nbtn  = '1;
      step(3);
      chk("rst_level",  level,  0);
      chk("rst_press",  press,  0);
      chk("rst_rel",    rel,    0);
      chk("rst_stroke", stroke, 0);
      reset = 1'b1;
      step(8);

      // Clean press on lane 0
      snap0 = press_cnt[0];
      nbtn[0] = 1'b0;
      t0 = cyc;
      step(10);
      chk("s1_press_lat",  press_cyc[0] - t0, 6);
      chk("s1_press_cnt",  press_cnt[0] - snap0, 1);
      chk("s1_stroke_lat", stroke_cyc[0] - t0, 6);
      chk("s1_level",      level[0], 1);

      // Bounce on lane 1: 2-cycle runs never reach S
      snap1 = press_cnt[1];
      for (int i = 0; i < 10; i++) begin
         nbtn[1] = i[0];
         step(2);
      end
      chk("s2_bounce_quiet", press_cnt[1] - snap1, 0);
      nbtn[1] = 1'b0;
      t0 = cyc;
      step(10);
      chk("s2_press_lat", press_cyc[1] - t0, 6);
      chk("s2_press_cnt", press_cnt[1] - snap1, 1);

      // Lanes 2 and 3 released together
      nbtn[3:2] = 2'b00;
      step(10);
      snap0 = press_cnt[2] + press_cnt[3];
      nbtn[3:2] = 2'b11;
      t0 = cyc;
      step(10);
      chk("s3_rel2_lat", rel_cyc[2] - t0, 6);
      chk("s3_rel3_lat", rel_cyc[3] - t0, 6);
      chk("s3_no_press", press_cnt[2] + press_cnt[3] - snap0, 0);

      // Reset three cycles into a debounce on lane 0; lane 1 stays held
      nbtn[0] = 1'b1;
      step(10);
      nbtn[0] = 1'b0;
      step(3);
      reset = 1'b0;
      #1;
      chk("s4_rst_level",  level,  0);
      chk("s4_rst_press",  press,  0);
      chk("s4_rst_stroke", stroke, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      tr = cyc;
      step(10);
      chk("s4_press0_lat", press_cyc[0] - tr, 6);
      chk("s4_press1_lat", press_cyc[1] - tr, 6);

      // Hold lane 0 so its release lands on a repeat expiry edge
      nbtn = '1;
      step(12);
      snap0 = stroke_cnt[0];
      nbtn[0] = 1'b0;
      t0 = cyc;
      step(6 + 31);
      nbtn[0] = 1'b1;
      step(15);
      chk("s5_rel_lat", rel_cyc[0] - t0, 6 + 31 + 6);
`ifdef BTN_PULSE_GEN_REPEAT_EN
      chk("s5_strokes", stroke_cnt[0] - snap0, 10);
`else
      chk("s5_strokes", stroke_cnt[0] - snap0, 1);
`endif

      // Randomized activity: alternating noisy and calm blocks, rare resets
      for (int blk = 0; blk < 60; blk++) begin
         prob = ($urandom_range(0, 1) == 0) ? 3 : 40;
         for (int c = 0; c < 50; c++) begin
            for (int ln = 0; ln < W; ln++) begin
               if ($urandom_range(0, prob - 1) == 0) nbtn[ln] = ~nbtn[ln];
            end
            if ($urandom_range(0, 299) == 0) begin
               reset = 1'b0;
               step(1);
               reset = 1'b1;
            end
            step(1);
         end
      end
      step(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
